// File: rtl/conv_ctrl_sequencer.sv
// Fetch/decode/execute controller for the convolution processor.
// Sequences IR load, PC update, ALU, register-file write and data-memory
// handshakes from the opcode field, and counts retired instructions.
// Optional build macro CONV_CTRL_MEM_TIMEOUT_EN adds a MEM_WAIT watchdog
// that aborts into a sticky error state when mem_ack never arrives.

module conv_ctrl_sequencer #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero_flag,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_wen,
  output logic             alu_en,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             complete,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMemWait,
    StWb,
    StHalt,
    StErr
  } state_e;

  localparam logic [OP_W-1:0] OpAlu   = OP_W'(1);
  localparam logic [OP_W-1:0] OpLoad  = OP_W'(2);
  localparam logic [OP_W-1:0] OpStore = OP_W'(3);
  localparam logic [OP_W-1:0] OpJmp   = OP_W'(4);
  localparam logic [OP_W-1:0] OpJz    = OP_W'(5);
  localparam logic [OP_W-1:0] OpJnz   = OP_W'(6);
  localparam logic [OP_W-1:0] OpHalt  = OP_W'(7);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

`ifdef CONV_CTRL_MEM_TIMEOUT_EN
  // Counter value seen on the TIMEOUT-th MEM_WAIT cycle (first cycle sees 0).
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [7:0] tmo_q, tmo_d;

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign err = (state_q == StErr);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign err            = 1'b0;
`endif

  // State and latched opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and strobe decode from state and latched opcode.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_wen  = 1'b0;
    alu_en  = 1'b0;
    reg_we  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
`ifdef CONV_CTRL_MEM_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        ir_load = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        op_d = opcode;
        case (opcode)
          OpLoad, OpStore: state_d = StMemWait;
          OpHalt:          state_d = StHalt;
          default:         state_d = StExec;
        endcase
`ifdef CONV_CTRL_MEM_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      StExec: begin
        state_d = StFetch;
        case (op_q)
          OpAlu: begin
            alu_en  = 1'b1;
            state_d = StWb;
          end
          OpJmp: pc_wen = 1'b1;
          OpJz: begin
            pc_wen = zero_flag;
            pc_inc = ~zero_flag;
          end
          OpJnz: begin
            pc_wen = ~zero_flag;
            pc_inc = zero_flag;
          end
          // NOP and unassigned opcodes just step the PC.
          default: pc_inc = 1'b1;
        endcase
      end
      StMemWait: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OpStore);
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack) state_d = StWb;
`ifdef CONV_CTRL_MEM_TIMEOUT_EN
        else if (tmo_q == TmoLast) state_d = StErr;
        else tmo_d = tmo_q + 8'd1;
`endif
      end
      StWb: begin
        pc_inc  = 1'b1;
        reg_we  = (op_q == OpAlu) || (op_q == OpLoad);
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  assign complete = (state_q == StHalt) || (state_q == StErr);
  assign busy     = (state_q != StIdle) && (state_q != StHalt) && (state_q != StErr);

  // Retired-instruction counter; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if ((pc_inc || pc_wen) && (instr_count != {CNT_W{1'b1}})) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_conv_ctrl_sequencer.sv
// Scoreboard bench for conv_ctrl_sequencer. Stimulus pushes expected strobe
// events (cycle relative to start, strobe vector, retired count); a negedge
// monitor pops and compares whenever any strobe is high.

module tb_conv_ctrl_sequencer;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  // Strobe vector bits: {ir_load, pc_inc, pc_wen, alu_en, reg_we, mem_req, mem_we}
  localparam logic [6:0] IR  = 7'b1000000;
  localparam logic [6:0] INC = 7'b0100000;
  localparam logic [6:0] WEN = 7'b0010000;
  localparam logic [6:0] ALU = 7'b0001000;
  localparam logic [6:0] RWE = 7'b0000100;
  localparam logic [6:0] REQ = 7'b0000010;
  localparam logic [6:0] MWE = 7'b0000001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [OP_W-1:0]  opcode;
  logic             zero_flag;
  logic             mem_ack;
  logic             ir_load, pc_inc, pc_wen, alu_en, reg_we, mem_req, mem_we;
  logic             complete, busy, err;
  logic [CNT_W-1:0] instr_count;

  conv_ctrl_sequencer #(
    .OP_W    (OP_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .zero_flag   (zero_flag),
    .mem_ack     (mem_ack),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_wen      (pc_wen),
    .alu_en      (alu_en),
    .reg_we      (reg_we),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .complete    (complete),
    .busy        (busy),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [6:0]       strb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] prog_q[$];  // {zero_flag, opcode} per fetched instruction
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         base = 0;
  int         ack_delay = 0;  // ack on this MEM_WAIT cycle (1-based); 0 = never
  logic       stray_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction supplier: each IR load takes the next program entry.
  initial begin
    opcode    = '0;
    zero_flag = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ir_load) begin
        if (prog_q.size() > 0) {zero_flag, opcode} = prog_q.pop_front();
        else {zero_flag, opcode} = 5'h07;
      end
    end
  end

  // Memory responder.
  initial begin
    int n;
    n       = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        n++;
        mem_ack = (ack_delay != 0) && (n == ack_delay);
      end else begin
        n       = 0;
        mem_ack = stray_ack;
      end
    end
  end

  // Monitor: compare every strobe event against the scoreboard.
  always @(negedge clk) begin
    logic [6:0] s;
    exp_t       e;
    s = {ir_load, pc_inc, pc_wen, alu_en, reg_we, mem_req, mem_we};
    if (rst_n === 1'b1 && s != 7'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got cyc=%0d strb=%b cnt=%0d, required no event",
                 cyc - base, s, instr_count);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc - base || e.strb !== s || e.cnt !== instr_count) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d strb=%b cnt=%0d, required cyc=%0d strb=%b cnt=%0d",
                   cyc - base, s, instr_count, e.cyc, e.strb, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic push(input int c, input logic [6:0] s, input int n);
    exp_t e;
    e.cyc  = c;
    e.strb = s;
    e.cnt  = CNT_W'(n);
    exp_q.push_back(e);
  endtask

  function automatic logic [9:0] all_outs();
    return {ir_load, pc_inc, pc_wen, alu_en, reg_we, mem_req, mem_we, complete, busy, err};
  endfunction

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    start     = 1'b0;
    ack_delay = 0;
    stray_ack = 1'b0;
    prog_q.delete();
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_reset_outputs"}, 32'(all_outs()), 32'd0);
    check({name, "_reset_count"}, 32'(instr_count), 32'd0);
    release_reset();
  endtask

  // Called at posedge+1 in IDLE: this cycle becomes cycle 0.
  task automatic launch();
    start = 1'b1;
    base  = cyc;
  endtask

  task automatic drop_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int want_cyc, input int want_cnt,
                           input logic want_err);
    int n;
    n = 0;
    while (complete !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 32'(complete), 32'd1);
    check({name, "_done_cycle"}, 32'(cyc - base), 32'(want_cyc));
    check({name, "_count"}, 32'(instr_count), 32'(want_cnt));
    check({name, "_err"}, 32'(err), 32'(want_err));
    check({name, "_busy"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;

    // NOP, HALT with start held high throughout.
    do_reset("t1");
    prog_q = '{5'h00, 5'h07};
    launch();
    push(1, IR, 0);
    push(3, INC, 0);
    push(4, IR, 1);
    wait_done("nop_halt", 6, 1, 1'b0);
    check("halt_sticky_complete", 32'(complete), 32'd1);
    check("halt_sticky_count", 32'(instr_count), 32'd1);

    // ALU, then LOAD acked on the third MEM_WAIT cycle.
    do_reset("t2");
    prog_q    = '{5'h01, 5'h02, 5'h07};
    ack_delay = 3;
    launch();
    push(1, IR, 0);
    push(3, ALU, 0);
    push(4, INC | RWE, 0);
    push(5, IR, 1);
    push(7, REQ, 1);
    push(8, REQ, 1);
    push(9, REQ, 1);
    push(10, INC | RWE, 1);
    push(11, IR, 2);
    drop_start();
    wait_done("alu_load", 13, 2, 1'b0);

    // Branches: JZ taken/not, JNZ taken/not, JMP, illegal opcode 9.
    do_reset("t3");
    prog_q = '{5'h15, 5'h05, 5'h06, 5'h16, 5'h04, 5'h09, 5'h07};
    launch();
    begin
      logic [6:0] exec_s[6];
      exec_s = '{WEN, INC, WEN, INC, WEN, INC};
      for (int k = 0; k < 6; k++) begin
        push(1 + 3 * k, IR, k);
        push(3 + 3 * k, exec_s[k], k);
      end
    end
    push(19, IR, 6);
    drop_start();
    wait_done("branches", 21, 6, 1'b0);

    // STORE with same-cycle ack; mem_ack held high outside MEM_WAIT.
    do_reset("t4");
    stray_ack = 1'b1;
    ack_delay = 1;
    prog_q    = '{5'h03, 5'h07};
    launch();
    push(1, IR, 0);
    push(3, REQ | MWE, 0);
    push(4, INC, 0);
    push(5, IR, 1);
    drop_start();
    wait_done("store", 7, 1, 1'b0);

    // Asynchronous reset in the middle of MEM_WAIT, then restart.
    do_reset("t5");
    prog_q = '{5'h00, 5'h02};
    launch();
    push(1, IR, 0);
    push(3, INC, 0);
    push(4, IR, 1);
    push(6, REQ, 1);
    push(7, REQ, 1);
    drop_start();
    repeat (7) @(posedge clk);
    #2;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    check("pre_reset_count", 32'(instr_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(all_outs()), 32'd0);
    check("async_reset_count", 32'(instr_count), 32'd0);
    check("async_reset_drained", 32'(exp_q.size()), 32'd0);
    prog_q.delete();
    release_reset();
    prog_q = '{5'h00, 5'h07};
    launch();
    push(1, IR, 0);
    push(3, INC, 0);
    push(4, IR, 1);
    drop_start();
    wait_done("restart", 6, 1, 1'b0);

    // Counter saturation: 17 NOPs with a 4-bit counter.
    do_reset("t6");
    for (int k = 0; k < 17; k++) prog_q.push_back(5'h00);
    prog_q.push_back(5'h07);
    launch();
    for (int k = 0; k < 17; k++) begin
      push(1 + 3 * k, IR, (k > 15) ? 15 : k);
      push(3 + 3 * k, INC, (k > 15) ? 15 : k);
    end
    push(52, IR, 15);
    drop_start();
    wait_done("saturate", 54, 15, 1'b0);

`ifdef CONV_CTRL_MEM_TIMEOUT_EN
    // LOAD never acked: ERR after TIMEOUT MEM_WAIT cycles.
    do_reset("t7");
    prog_q = '{5'h02};
    launch();
    push(1, IR, 0);
    for (int k = 3; k < 3 + 16; k++) push(k, REQ, 0);
    drop_start();
    wait_done("timeout", 19, 0, 1'b1);

    // Ack on the 16th MEM_WAIT cycle wins over the timeout.
    do_reset("t8");
    prog_q    = '{5'h02, 5'h07};
    ack_delay = 16;
    launch();
    push(1, IR, 0);
    for (int k = 3; k < 3 + 16; k++) push(k, REQ, 0);
    push(19, INC | RWE, 0);
    push(20, IR, 1);
    drop_start();
    wait_done("late_ack", 22, 1, 1'b0);
`else
    // Without the watchdog, MEM_WAIT waits indefinitely and err stays low.
    do_reset("t7");
    prog_q = '{5'h02};
    launch();
    push(1, IR, 0);
    for (int k = 3; k <= 22; k++) push(k, REQ, 0);
    drop_start();
    repeat (22) @(negedge clk);
    check("no_timeout_err", 32'(err), 32'd0);
    check("no_timeout_busy", 32'(busy), 32'd1);
    check("no_timeout_complete", 32'(complete), 32'd0);
    check("no_timeout_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    check("no_timeout_drained", 32'(exp_q.size()), 32'd0);
    do_reset("t8");
`endif

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
